// File: rtl/tia_horizontal_timing_pkg.sv
// Shared constants for the horizontal timing generator: LFSR width, line
// length, the LFSR shift rule and the LFSR codes of the decoded line steps.
package tia_horizontal_timing_pkg;

  localparam int LFSR_W         = 6;
  localparam int LINE_STEPS_DEF = 57;

  // One LFSR step: shift left, feed back XNOR of the two top bits
  function automatic logic [LFSR_W-1:0] lfsr_shift(input logic [LFSR_W-1:0] l);
    return {l[LFSR_W-2:0], ~(l[LFSR_W-1] ^ l[LFSR_W-2])};
  endfunction

  // LFSR code reached n steps after the all-zero state
  function automatic logic [LFSR_W-1:0] lfsr_at(input int n);
    logic [LFSR_W-1:0] l;
    l = '0;
    for (int i = 0; i < n; i++) l = lfsr_shift(l);
    return l;
  endfunction

  localparam logic [LFSR_W-1:0] H_S0  = lfsr_at(0);
  localparam logic [LFSR_W-1:0] H_S4  = lfsr_at(4);
  localparam logic [LFSR_W-1:0] H_S8  = lfsr_at(8);
  localparam logic [LFSR_W-1:0] H_S16 = lfsr_at(16);
  localparam logic [LFSR_W-1:0] H_S18 = lfsr_at(18);
  localparam logic [LFSR_W-1:0] H_S36 = lfsr_at(36);
  localparam logic [LFSR_W-1:0] H_S56 = lfsr_at(LINE_STEPS_DEF - 1);

endpackage

// File: rtl/tia_horizontal_timing_lfsr6.sv
// 6-bit horizontal LFSR: shift enable, synchronous clear, reload to zero
// from the terminal step (or from the unreachable all-ones lock-up state).
module tia_lfsr6
  import tia_horizontal_timing_pkg::*;
#(
  parameter logic [LFSR_W-1:0] TERM = H_S56
) (
  input  logic              clkp,
  input  logic              reset_bar,
  input  logic              i_en,
  input  logic              i_clr,
  output logic [LFSR_W-1:0] o_q,
  output logic [LFSR_W-1:0] o_nxt
);

  logic [LFSR_W-1:0] r_q;

  // Next code; exposed so the top can decode registered outputs with zero lag
  always_comb begin
    o_nxt = r_q;
    if (i_clr)
      o_nxt = '0;
    else if (i_en)
      o_nxt = (r_q == TERM || r_q == '1) ? '0 : lfsr_shift(r_q);
  end

  // LFSR state register
  always_ff @(posedge clkp or negedge reset_bar) begin
    if (!reset_bar) r_q <= '0;
    else            r_q <= o_nxt;
  end

  assign o_q = r_q;

endmodule

// File: rtl/tia_horizontal_timing.sv
// Horizontal sync/timing generator: clkp/4 phase strobes, 57-step LFSR line
// counter and registered line-event decode. Optional late-HBLANK release
// (HMOVE) is built when TIA_HORIZONTAL_LATE_HBLANK_EN is defined.
module tia_horizontal_timing
  import tia_horizontal_timing_pkg::*;
#(
  parameter int LINE_STEPS = LINE_STEPS_DEF
) (
  input  logic              clkp,
  input  logic              reset_bar,
  input  logic              rsync,
  input  logic              hmove,
  output logic              hphi1,
  output logic              hphi2,
  output logic [LFSR_W-1:0] hcount,
  output logic              shb,
  output logic              rhb,
  output logic              cnt,
  output logic              hsync,
  output logic              hblank,
  output logic              line_start
);

  logic [1:0]        r_phase, w_phase_nxt;
  logic [LFSR_W-1:0] w_lfsr, w_lfsr_nxt;
  logic              w_adv, w_chg, w_ent0, w_rel, w_late_set;
  logic              r_late;
  logic              r_hphi1, r_hphi2, r_shb, r_rhb, r_cnt, r_hsync, r_hblank, r_lstart;

  assign w_adv       = (r_phase == 2'd3);
  assign w_phase_nxt = rsync ? 2'd0 : r_phase + 2'd1;
  // Step boundary: either a normal advance or an RSYNC restart
  assign w_chg       = rsync | w_adv;

  tia_lfsr6 #(.TERM(lfsr_at(LINE_STEPS - 1))) u_lfsr (
    .clkp      (clkp),
    .reset_bar (reset_bar),
    .i_en      (w_adv),
    .i_clr     (rsync),
    .o_q       (w_lfsr),
    .o_nxt     (w_lfsr_nxt)
  );

`ifdef TIA_HORIZONTAL_LATE_HBLANK_EN
  assign w_late_set = hmove;
`else
  logic w_unused_hmove;
  assign w_unused_hmove = hmove;
  assign w_late_set     = 1'b0;
`endif

  assign w_ent0 = w_chg & (w_lfsr_nxt == H_S0);
  // Release decided once per line: step 16 if not late, else step 18
  // (gated by hblank so a late arm after an early release cannot re-fire rhb)
  assign w_rel  = w_chg & (((w_lfsr_nxt == H_S16) & ~r_late) |
                           ((w_lfsr_nxt == H_S18) & r_late & r_hblank));

  // Phase counter, restarted by rsync
  always_ff @(posedge clkp or negedge reset_bar) begin
    if (!reset_bar) r_phase <= 2'd0;
    else            r_phase <= w_phase_nxt;
  end

  // Late latch: hmove sets (wins over clear), step-0 entry clears
  always_ff @(posedge clkp or negedge reset_bar) begin
    if (!reset_bar)      r_late <= 1'b0;
    else if (w_late_set) r_late <= 1'b1;
    else if (w_ent0)     r_late <= 1'b0;
  end

  // Registered decode, computed from next phase/LFSR so it tracks hcount
  always_ff @(posedge clkp or negedge reset_bar) begin
    if (!reset_bar) begin
      r_hphi1  <= 1'b1;
      r_hphi2  <= 1'b0;
      r_shb    <= 1'b1;
      r_rhb    <= 1'b0;
      r_cnt    <= 1'b0;
      r_hsync  <= 1'b0;
      r_hblank <= 1'b1;
      r_lstart <= 1'b1;
    end else begin
      r_hphi1  <= (w_phase_nxt == 2'd0);
      r_hphi2  <= (w_phase_nxt == 2'd2);
      r_lstart <= (w_phase_nxt == 2'd0) && (w_lfsr_nxt == H_S0);
      if (w_chg) begin
        r_shb <= (w_lfsr_nxt == H_S0);
        r_cnt <= (w_lfsr_nxt == H_S36);
        r_rhb <= w_rel;
        if (w_lfsr_nxt == H_S4)                              r_hsync <= 1'b1;
        else if (w_lfsr_nxt == H_S8 || w_lfsr_nxt == H_S0)   r_hsync <= 1'b0;
        if (w_ent0)     r_hblank <= 1'b1;
        else if (w_rel) r_hblank <= 1'b0;
      end
    end
  end

  assign hphi1      = r_hphi1;
  assign hphi2      = r_hphi2;
  assign hcount     = w_lfsr;
  assign shb        = r_shb;
  assign rhb        = r_rhb;
  assign cnt        = r_cnt;
  assign hsync      = r_hsync;
  assign hblank     = r_hblank;
  assign line_start = r_lstart;

endmodule

// File: tb/tb_tia_horizontal_timing.sv
// Bench for tia_horizontal_timing: per-clkp comparison against a model that
// tracks clkp-within-line and derives every output from step/phase arithmetic.
module tb_tia_horizontal_timing;

  logic       clkp = 1'b0;
  logic       reset_bar = 1'b0;
  logic       rsync = 1'b0;
  logic       hmove = 1'b0;
  logic       hphi1, hphi2, shb, rhb, cnt, hsync, hblank, line_start;
  logic [5:0] hcount;

  tia_horizontal_timing dut (
    .clkp       (clkp),
    .reset_bar  (reset_bar),
    .rsync      (rsync),
    .hmove      (hmove),
    .hphi1      (hphi1),
    .hphi2      (hphi2),
    .hcount     (hcount),
    .shb        (shb),
    .rhb        (rhb),
    .cnt        (cnt),
    .hsync      (hsync),
    .hblank     (hblank),
    .line_start (line_start)
  );

  always #5 clkp = ~clkp;

`ifdef TIA_HORIZONTAL_LATE_HBLANK_EN
  localparam bit LATE_EN = 1'b1;
`else
  localparam bit LATE_EN = 1'b0;
`endif

  int         n_chk = 0;
  int         n_bad = 0;
  logic [5:0] tab [57];
  int         k;       // clkp index within the current line (0..227)
  bit         m_late;
  int         m_rel;   // step on which hblank releases this line

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h want=%0h k=%0d t=%0t", tag, obs, exp, k, $time);
    end
  endtask

  task automatic check_all();
    int ph, st;
    ph = k % 4;
    st = k / 4;
    chk("hphi1",  8'(hphi1),      8'(ph == 0));
    chk("hphi2",  8'(hphi2),      8'(ph == 2));
    chk("hcount", 8'(hcount),     8'(tab[st]));
    chk("shb",    8'(shb),        8'(st == 0));
    chk("rhb",    8'(rhb),        8'(st == m_rel));
    chk("cnt",    8'(cnt),        8'(st == 36));
    chk("hsync",  8'(hsync),      8'(st >= 4 && st < 8));
    chk("hblank", 8'(hblank),     8'(st < m_rel));
    chk("lstart", 8'(line_start), 8'(k == 0));
    chk("no3f",   8'(hcount == 6'h3f), 8'd0);
  endtask

  task automatic model_reset();
    k = 0;
    m_late = 1'b0;
    m_rel = 16;
  endtask

  task automatic model_edge(input bit rs, input bit hm);
    bit hm_eff;
    hm_eff = LATE_EN && hm;
    if (rs) begin
      k = 0;
      m_late = hm_eff;
    end else begin
      k = (k + 1) % 228;
      if (k == 64) m_rel = m_late ? 18 : 16;
      m_late = hm_eff ? 1'b1 : ((k == 0) ? 1'b0 : m_late);
    end
  endtask

  task automatic cyc(input bit rs, input bit hm);
    rsync = rs;
    hmove = hm;
    @(posedge clkp);
    model_edge(rs, hm);
    @(negedge clkp);
    check_all();
  endtask

  task automatic run_until(input int target);
    int n;
    n = 0;
    while (k != target && n < 500) begin
      cyc(1'b0, 1'b0);
      n++;
    end
  endtask

  initial begin
    tab[0] = 6'd0;
    for (int i = 1; i < 57; i++)
      tab[i] = {tab[i-1][4:0], ~(tab[i-1][5] ^ tab[i-1][4])};

    model_reset();
    @(negedge clkp);
    @(negedge clkp);
    check_all();
    reset_bar = 1'b1;

    // Two free-running lines
    for (int i = 0; i < 460; i++) cyc(1'b0, 1'b0);

    // RSYNC at clkp 100 of a line
    run_until(100);
    cyc(1'b1, 1'b0);
    for (int i = 0; i < 40; i++) cyc(1'b0, 1'b0);

    // HMOVE at clkp 10, then a following line without HMOVE
    run_until(10);
    cyc(1'b0, 1'b1);
    for (int i = 0; i < 300; i++) cyc(1'b0, 1'b0);

    // HMOVE coinciding with step-0 entry
    run_until(227);
    cyc(1'b0, 1'b1);
    for (int i = 0; i < 100; i++) cyc(1'b0, 1'b0);

    // Held RSYNC for a few clkp
    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0);
    for (int i = 0; i < 30; i++) cyc(1'b0, 1'b0);

    // Random RSYNC/HMOVE traffic
    for (int i = 0; i < 4000; i++)
      cyc($urandom_range(0, 299) == 0, $urandom_range(0, 59) == 0);

    // Asynchronous reset mid-step (phase 2), checked between edges
    run_until(150);
    #2 reset_bar = 1'b0;
    #1 model_reset();
    check_all();
    @(posedge clkp);
    @(negedge clkp);
    check_all();
    reset_bar = 1'b1;
    for (int i = 0; i < 100; i++) cyc(1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
